// File: rtl/stc0_egress_word_assembler_pkg.sv
// Shared constants and lane typing for the stc0 egress word assembler.
package stc0_egress_word_assembler_pkg;

  localparam int unsigned STC0_WORD_BYTES     = 4;
  localparam int unsigned DEF_FIFO_DEPTH      = 16;
  localparam int unsigned DEF_FIFO_DEPTH_LOG2 = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1023;

  // LANE_0 is the most significant byte of the assembled word.
  typedef enum logic [1:0] {
    LANE_0 = 2'd0,
    LANE_1 = 2'd1,
    LANE_2 = 2'd2,
    LANE_3 = 2'd3
  } lane_e;

  function automatic lane_e next_lane(input lane_e l);
    return lane_e'(l + 2'd1);
  endfunction

endpackage

// File: rtl/stc0_egress_word_assembler_if.sv
// Byte-in / word-out handshake and status bundle of the egress word assembler.
interface stc0_egress_word_assembler_if #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
);
  logic [7:0]               ED;
  logic                     EValid;
  logic [31:0]              Word;
  logic                     WordValid;
  logic                     WordReady;
  logic [FIFO_DEPTH_LOG2:0] Level;
  logic                     Overflow;
  logic                     Timeout;
  logic                     ClearStatus;

  modport master (
    output ED, EValid, WordReady, ClearStatus,
    input  Word, WordValid, Level, Overflow, Timeout
  );

  modport slave (
    input  ED, EValid, WordReady, ClearStatus,
    output Word, WordValid, Level, Overflow, Timeout
  );
endinterface

// File: rtl/stc0_egress_word_assembler_fifo.sv
// stc0_sync_fifo: synchronous FIFO with extra-MSB pointers; head is read combinationally
// from registered storage, so a write becomes visible one cycle later.
module stc0_sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_pop;
  logic                do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/stc0_egress_word_assembler.sv
// Packs the stc0 egress byte stream MSB-first into 32-bit words and buffers them.
// Optional partial-word timeout is built when STC0_EGRESS_TIMEOUT_EN is defined.
module stc0_egress_word_assembler
  import stc0_egress_word_assembler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned FIFO_DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input logic                          Clk,
  input logic                          ARst,
  stc0_egress_word_assembler_if.slave  bus
);

  localparam int unsigned WORD_W = STC0_WORD_BYTES * 8;

  lane_e             idx;
  logic [23:0]       shreg;
  logic [WORD_W-1:0] word_in;
  logic              byte_last;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              timeout_fire;
  logic              overflow_q;

  assign byte_last = bus.EValid && (idx == LANE_3);
  assign word_in   = {shreg, bus.ED};
  assign pop       = !fifo_empty && bus.WordReady;
  assign push_ok   = byte_last && (!fifo_full || pop);
  assign drop      = byte_last && fifo_full && !pop;

  // Lane index wraps even on a dropped word so alignment is never lost.
  always_ff @(posedge Clk) begin
    if (ARst) begin
      idx   <= LANE_0;
      shreg <= '0;
    end else if (timeout_fire) begin
      idx   <= LANE_0;
    end else if (bus.EValid) begin
      idx   <= next_lane(idx);
      shreg <= {shreg[15:0], bus.ED};
    end
  end

  always_ff @(posedge Clk) begin
    if (ARst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop | (overflow_q & ~bus.ClearStatus);
    end
  end

`ifdef STC0_EGRESS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            timeout_q;

  assign timeout_fire = (idx != LANE_0) && !bus.EValid &&
                        (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (ARst) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (bus.EValid || (idx == LANE_0) || timeout_fire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
      timeout_q <= timeout_fire | (timeout_q & ~bus.ClearStatus);
    end
  end

  assign bus.Timeout = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign bus.Timeout  = 1'b0;
`endif

  stc0_sync_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (Clk),
    .rst       (ARst),
    .push      (push_ok),
    .push_data (word_in),
    .pop       (pop),
    .pop_data  (bus.Word),
    .level     (bus.Level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.WordValid = !fifo_empty;
  assign bus.Overflow  = overflow_q;

endmodule
